// File: rtl/button_event_arbiter_pkg.sv
// button_pkg: shared types, default timing constants and round-robin search for the button arbiter
package button_pkg;

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} chan_state_t;

    localparam int TICK_DIV_DEF   = 1_000_000;
    localparam int DEB_TICKS_DEF  = 3;
    localparam int HOLD_TICKS_DEF = 300;

    // First set bit of req searching upward from ptr with wrap over n entries; ptr if none set.
    function automatic logic [2:0] next_rr(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] g;
        logic [2:0] idx;
        g = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && req[idx]) g = idx;
        end
        return g;
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// button_event_arbiter_if: valid/ready event stream carrying a button index and press type
interface button_event_arbiter_if #(parameter int N_BTN = 4);
    localparam int CODE_W = $clog2(N_BTN);
    logic              evt_valid;
    logic              evt_ready;
    logic [CODE_W-1:0] evt_code;
    logic              evt_long;
    modport master (output evt_valid, evt_code, evt_long, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_long, output evt_ready);
endinterface

// File: rtl/button_event_arbiter_channel.sv
// button_channel: synchronise, debounce and classify presses of one button as short or long
module button_channel
    import button_pkg::*;
#(
    parameter int DEB_TICKS  = DEB_TICKS_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic req_short,
    output logic req_long
);
    localparam int HW = $clog2(HOLD_TICKS);

    logic s1, s2, armed;
    logic [3:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    chan_state_t state, state_nxt;

    // Edges are taken from the level about to be written so a fall and the hold threshold can share a tick.
    wire       differ  = s2 != level;
    wire [3:0] deb_inc = deb_cnt + 4'd1;
    wire       flip    = tick && differ && deb_inc == 4'(DEB_TICKS);
    wire       rise    = flip && !level && armed;
    wire       fall    = flip && level;
    wire       at_hold = tick && hold_cnt == HW'(HOLD_TICKS - 1);

    // Synchroniser every cycle; debounce and arming (button seen released since reset) on tick.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            deb_cnt <= '0;
            level   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            if (tick) begin
                deb_cnt <= (!differ || flip) ? 4'd0 : deb_inc;
                level   <= level ^ flip;
                if (!s2) armed <= 1'b1;
            end
        end
    end

    // State register and hold counter, which only runs while PRESSED.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state != PRESSED) hold_cnt <= '0;
            else if (tick && !at_hold) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Next state: a fall while PRESSED wins over the hold threshold.
    always_comb begin
        state_nxt = (state == IDLE)    ? (rise ? PRESSED : IDLE) :
                    (state == PRESSED) ? (fall ? IDLE : at_hold ? HELD : PRESSED) :
                                         (fall ? IDLE : HELD);
    end

    // One request per press, issued on the transition out of PRESSED.
    always_comb begin
        req_short = state == PRESSED && fall;
        req_long  = state == PRESSED && !fall && at_hold;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: shared sample tick, per-button pending events and round-robin event output
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int DEB_TICKS  = DEB_TICKS_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       btn,
    input  logic                   clr_lost,
    output logic [N_BTN-1:0]       btn_level,
    output logic                   evt_lost,
    button_event_arbiter_if.master evt
);
    localparam int CODE_W = $clog2(N_BTN);
    localparam int TW     = $clog2(TICK_DIV);

    logic [TW-1:0] tick_cnt;
    logic [N_BTN-1:0] req_s, req_l, req, pend, pend_long, pend_eff, long_eff, gmask;
    logic [CODE_W-1:0] rr_ptr, g;
    logic slot_free, grant, lost_set;

    wire tick = tick_cnt == TW'(TICK_DIV - 1);

    // Free-running divider producing the shared sample tick.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(.DEB_TICKS(DEB_TICKS), .HOLD_TICKS(HOLD_TICKS)) u_chan (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .tick     (tick),
            .btn_raw  (btn[i]),
            .level    (btn_level[i]),
            .req_short(req_s[i]),
            .req_long (req_l[i])
        );
    end

    // Arbitrate over stored and same-cycle requests; a stored event is granted before a fresh one replaces it.
    always_comb begin
        req       = req_s | req_l;
        pend_eff  = pend | req;
        long_eff  = (pend & pend_long) | (~pend & req_l);
        slot_free = !evt.evt_valid || evt.evt_ready;
        grant     = slot_free && |pend_eff;
        g         = CODE_W'(next_rr(8'(pend_eff), 3'(rr_ptr), N_BTN));
        gmask     = grant ? (N_BTN'(1) << g) : '0;
        lost_set  = |(req & pend & ~gmask);
    end

    // Pending store, output slot, round-robin pointer and sticky loss flag.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pend          <= '0;
            pend_long     <= '0;
            rr_ptr        <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_code  <= '0;
            evt.evt_long  <= 1'b0;
            evt_lost      <= 1'b0;
        end else begin
            pend      <= ((pend & ~gmask) | req) & ~(gmask & ~pend);
            pend_long <= (req & req_l) | (~req & pend_long);
            evt_lost  <= lost_set ? 1'b1 : clr_lost ? 1'b0 : evt_lost;
            if (grant) begin
                evt.evt_valid <= 1'b1;
                evt.evt_code  <= g;
                evt.evt_long  <= long_eff[g];
                rr_ptr        <= (g == CODE_W'(N_BTN - 1)) ? '0 : g + 1'b1;
            end else if (slot_free) begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed presses with a scoreboard of expected events checked by a monitor
module tb_button_event_arbiter;

    typedef struct {
        logic [1:0] code;
        logic       lng;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_lost = 1'b0;
    logic [3:0] btn = '0;
    logic [3:0] btn_level;
    logic       evt_lost;
    exp_t       q[$];
    time        tq[$];
    int         tests = 0;
    int         fails = 0;

    button_event_arbiter_if #(.N_BTN(4)) evt_if ();

    button_event_arbiter #(.N_BTN(4), .TICK_DIV(4), .DEB_TICKS(3), .HOLD_TICKS(10)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .btn      (btn),
        .clr_lost (clr_lost),
        .btn_level(btn_level),
        .evt_lost (evt_lost),
        .evt      (evt_if)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        cyc(4 * n);
    endtask

    task automatic expect_evt(input int code, input int lng);
        exp_t e;
        e.code = 2'(code);
        e.lng  = lng[0];
        q.push_back(e);
    endtask

    task automatic press(input logic [3:0] mask, input int n);
        btn = btn | mask;
        ticks(n);
        btn = btn & ~mask;
        ticks(6);
    endtask

    // Monitor: every accepted transfer is compared with the oldest expected event.
    always @(negedge clk_in) begin
        if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            exp_t e;
            tq.push_back($time);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_evt: got code %0d long %0d expected none at %0t",
                         evt_if.evt_code, evt_if.evt_long, $time);
            end else begin
                e = q.pop_front();
                check("evt_code", evt_if.evt_code, e.code);
                check("evt_long", evt_if.evt_long, e.lng);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        evt_if.evt_ready = 1'b1;
        cyc(3);
        check("rst_valid", evt_if.evt_valid, 0);
        check("rst_level", btn_level, 0);
        check("rst_lost", evt_lost, 0);
        rst_n = 1'b1;
        ticks(2);

        // Short press of button 2; level must rise on the third tick after the press.
        btn[2] = 1'b1;
        expect_evt(2, 0);
        ticks(2);
        check("lvl2_before_3ticks", btn_level[2], 0);
        ticks(1);
        check("lvl2_at_3ticks", btn_level[2], 1);
        ticks(3);
        btn[2] = 1'b0;
        ticks(6);
        check("short_drained", q.size(), 0);

        // Long press of button 1: no event before the hold time, exactly one after.
        btn[1] = 1'b1;
        expect_evt(1, 1);
        ticks(10);
        check("long_not_early", q.size(), 1);
        ticks(5);
        check("long_drained", q.size(), 0);
        btn[1] = 1'b0;
        ticks(6);
        check("long_release_quiet", tq.size(), 2);

        // Two-tick glitch on button 0 never changes the level.
        btn[0] = 1'b1;
        ticks(2);
        btn[0] = 1'b0;
        ticks(1);
        check("glitch_lvl_a", btn_level[0], 0);
        ticks(4);
        check("glitch_lvl_b", btn_level[0], 0);
        check("glitch_no_evt", tq.size(), 2);

        // Round robin: pointer is 2 here; a press on 3 moves it to 0.
        expect_evt(3, 0);
        press(4'b1000, 5);
        expect_evt(0, 0);
        expect_evt(1, 0);
        expect_evt(3, 0);
        press(4'b1011, 5);
        check("rr0_drained", q.size(), 0);
        check("rr0_back_to_back", int'(tq[tq.size()-1] - tq[tq.size()-3]), 20);
        expect_evt(1, 0);
        press(4'b0010, 5);
        expect_evt(3, 0);
        expect_evt(0, 0);
        expect_evt(1, 0);
        press(4'b1011, 5);
        check("rr2_drained", q.size(), 0);
        check("rr2_back_to_back", int'(tq[tq.size()-1] - tq[tq.size()-3]), 20);

        // Stalled consumer: second pending event for button 3 overwrites the first.
        evt_if.evt_ready = 1'b0;
        expect_evt(2, 0);
        press(4'b0100, 5);
        check("stall_valid", evt_if.evt_valid, 1);
        press(4'b1000, 5);
        check("stall_no_lost_yet", evt_lost, 0);
        press(4'b1000, 5);
        expect_evt(3, 0);
        check("lost_set", evt_lost, 1);
        check("stall_code_held", evt_if.evt_code, 2);
        evt_if.evt_ready = 1'b1;
        cyc(4);
        check("lost_drained", q.size(), 0);
        ticks(3);
        check("lost_single_evt", q.size(), 0);
        check("lost_sticky", evt_lost, 1);
        clr_lost = 1'b1;
        cyc(1);
        clr_lost = 1'b0;
        check("lost_cleared", evt_lost, 0);

        // Reset in the middle of a hold discards the press.
        btn[1] = 1'b1;
        ticks(8);
        check("hold_lvl_before_rst", btn_level[1], 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", evt_if.evt_valid, 0);
        check("midrst_code", evt_if.evt_code, 0);
        check("midrst_long", evt_if.evt_long, 0);
        check("midrst_level", btn_level, 0);
        check("midrst_lost", evt_lost, 0);
        cyc(2);
        rst_n = 1'b1;
        ticks(20);
        check("held_through_rst_level", btn_level[1], 1);
        check("held_through_rst_quiet", q.size(), 0);
        btn[1] = 1'b0;
        ticks(6);
        expect_evt(1, 0);
        press(4'b0010, 5);
        check("repress_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
